piradip_stream_to_lanes: RTL and testbench

- Parametrised successor to the 1-bit word serializer.
- Takes WIDTH-bit AXI-Stream words and emits them as a stream of LANES-bit slices, with selectable slice order and a per-word tlast.
- Double-buffered, so back-to-back words stream with no bubbles.
- Sits between a word-level AXIS manager and a narrow bit/lane stream consumer (radio sample/bit pipelines).

---
 rtl/piradip_stream_to_lanes.sv | 115 +++++++++++
 tb/tb_piradip_stream_to_lanes.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piradip_stream_to_lanes.sv
// piradip_stream_to_lanes
// Splits WIDTH-bit AXI-Stream words into LANES-bit output beats.
// Storage is one shift register (SR) that is being emitted plus one hold
// register (HR) that catches the next word, so consecutive words leave
// back-to-back with no idle beat between them. tlast marks the final slice
// of every word. align flushes everything without emitting a tlast.

module piradip_stream_to_lanes #(
    parameter int WIDTH     = 32,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             align,
    input  logic [WIDTH-1:0] words_in_tdata,
    input  logic             words_in_tvalid,
    output logic             words_in_tready,
    output logic [LANES-1:0] bits_out_tdata,
    output logic             bits_out_tvalid,
    input  logic             bits_out_tready,
    output logic             bits_out_tlast,
    output logic             busy
);

    localparam int SLICES = WIDTH / LANES;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SLICES - 1);

    generate
        if ((WIDTH % LANES) != 0) begin : g_bad_lanes
            $error("piradip_stream_to_lanes: WIDTH must be a multiple of LANES");
        end
    endgenerate

    logic [WIDTH-1:0] r_sr;
    logic             r_sr_valid;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hr;
    logic             r_hr_valid;

    logic w_last;
    logic w_fire_out;
    logic w_fire_in;
    logic w_sr_free;

    // Move the next slice to the emitting end of the shift register.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            advance = v << LANES;
        end else begin
            advance = v >> LANES;
        end
    endfunction

    // Input readiness depends only on the hold register being empty; a word
    // arriving during rst or align would be discarded, so refuse it.
    assign words_in_tready = ~r_hr_valid & ~rst & ~align;

    assign w_last     = r_sr_valid & (r_cnt == LAST_CNT);
    assign w_fire_out = r_sr_valid & bits_out_tready;
    assign w_fire_in  = words_in_tvalid & words_in_tready;
    // SR can take a new word when empty or when its final slice leaves now.
    assign w_sr_free  = ~r_sr_valid | (w_fire_out & w_last);

    assign bits_out_tvalid = r_sr_valid;
    assign bits_out_tlast  = w_last;
    assign busy            = r_sr_valid | r_hr_valid;

    generate
        if (MSB_FIRST) begin : g_msb
            assign bits_out_tdata = r_sr[WIDTH-1 -: LANES];
        end else begin : g_lsb
            assign bits_out_tdata = r_sr[LANES-1:0];
        end
    endgenerate

    // Shift/hold register update: reset and align clear, otherwise refill SR
    // from HR first, then straight from the input, and park extra words in HR.
    always_ff @(posedge clk) begin
        if (rst || align) begin
            r_sr       <= '0;
            r_sr_valid <= 1'b0;
            r_cnt      <= '0;
            r_hr       <= '0;
            r_hr_valid <= 1'b0;
        end else if (w_sr_free) begin
            r_cnt <= '0;
            if (r_hr_valid) begin
                r_sr       <= r_hr;
                r_sr_valid <= 1'b1;
                if (w_fire_in) begin
                    r_hr <= words_in_tdata;
                end else begin
                    r_hr_valid <= 1'b0;
                end
            end else if (w_fire_in) begin
                r_sr       <= words_in_tdata;
                r_sr_valid <= 1'b1;
            end else begin
                r_sr_valid <= 1'b0;
            end
        end else begin
            if (w_fire_out) begin
                r_sr  <= advance(r_sr);
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_fire_in) begin
                r_hr       <= words_in_tdata;
                r_hr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piradip_stream_to_lanes.sv
// Bench for piradip_stream_to_lanes. Three instances cover LANES=4 MSB-first
// (a), LANES=4 LSB-first (b) and LANES=1 MSB-first (c). A word-level
// scoreboard predicts each slice by arithmetic on the accepted word and the
// beat index, and predicts valid/ready/busy from the number of words held.

module tb_piradip_stream_to_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic align;

    logic [31:0] a_din, b_din, c_din;
    logic        a_vin, b_vin, c_vin;
    logic        a_rdy, b_rdy, c_rdy;
    logic [3:0]  a_dout, b_dout;
    logic [0:0]  c_dout;
    logic        a_vout, b_vout, c_vout;
    logic        a_tready, b_tready, c_tready;
    logic        a_last, b_last, c_last;
    logic        a_busy, b_busy, c_busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] words[$];

    piradip_stream_to_lanes #(.WIDTH(32), .LANES(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .align(align),
        .words_in_tdata(a_din), .words_in_tvalid(a_vin), .words_in_tready(a_rdy),
        .bits_out_tdata(a_dout), .bits_out_tvalid(a_vout), .bits_out_tready(a_tready),
        .bits_out_tlast(a_last), .busy(a_busy));

    piradip_stream_to_lanes #(.WIDTH(32), .LANES(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .align(align),
        .words_in_tdata(b_din), .words_in_tvalid(b_vin), .words_in_tready(b_rdy),
        .bits_out_tdata(b_dout), .bits_out_tvalid(b_vout), .bits_out_tready(b_tready),
        .bits_out_tlast(b_last), .busy(b_busy));

    piradip_stream_to_lanes #(.WIDTH(32), .LANES(1), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst(rst), .align(align),
        .words_in_tdata(c_din), .words_in_tvalid(c_vin), .words_in_tready(c_rdy),
        .bits_out_tdata(c_dout), .bits_out_tvalid(c_vout), .bits_out_tready(c_tready),
        .bits_out_tlast(c_last), .busy(c_busy));

    function automatic int slices_of(input int sel);
        return (sel == 2) ? 32 : 8;
    endfunction

    // Expected slice k of word w, straight from the slice-order rule.
    function automatic logic [3:0] exp_slice(input int sel, input logic [31:0] w, input int k);
        int lanes;
        int sh;
        logic [31:0] t;
        lanes = (sel == 2) ? 1 : 4;
        sh    = (sel == 1) ? lanes * k : 32 - lanes * (k + 1);
        t     = (w >> sh) & ((32'd1 << lanes) - 32'd1);
        return t[3:0];
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] d, input logic tr);
        case (sel)
            0: begin a_vin = v; a_din = d; a_tready = tr; end
            1: begin b_vin = v; b_din = d; b_tready = tr; end
            default: begin c_vin = v; c_din = d; c_tready = tr; end
        endcase
    endtask

    task automatic observe(input int sel, output logic v, output logic [3:0] d,
                           output logic l, output logic r, output logic b);
        case (sel)
            0: begin v = a_vout; d = a_dout; l = a_last; r = a_rdy; b = a_busy; end
            1: begin v = b_vout; d = b_dout; l = b_last; r = b_rdy; b = b_busy; end
            default: begin v = c_vout; d = {3'b000, c_dout}; l = c_last; r = c_rdy; b = c_busy; end
        endcase
    endtask

    // Streams every entry of 'words' through instance sel, checking each cycle
    // against the scoreboard. Starts and ends just after a rising edge.
    task automatic run_stream(input int sel, input string name, input bit rand_ready, input int budget);
        logic [31:0] q[$];
        int k = 0, idx = 0, cyc = 0, beats = 0;
        int ns;
        logic v, l, r, b, tr;
        logic [3:0] d;
        logic pv = 1'b0, ptr = 1'b1, pl = 1'b0;
        logic [3:0] pd = 4'd0;
        ns = slices_of(sel);
        while ((idx < words.size() || q.size() > 0) && cyc < budget) begin
            tr = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            drive(sel, idx < words.size(), (idx < words.size()) ? words[idx] : 32'd0, tr);
            @(negedge clk);
            observe(sel, v, d, l, r, b);
            checks++;
            if (v !== (q.size() > 0)) begin
                failures++;
                $display("FAIL %s valid cyc=%0d: got %b want %b", name, cyc, v, q.size() > 0);
            end
            checks++;
            if (r !== (q.size() < 2)) begin
                failures++;
                $display("FAIL %s ready cyc=%0d: got %b want %b", name, cyc, r, q.size() < 2);
            end
            checks++;
            if (b !== (q.size() > 0)) begin
                failures++;
                $display("FAIL %s busy cyc=%0d: got %b want %b", name, cyc, b, q.size() > 0);
            end
            if (q.size() > 0 && v === 1'b1) begin
                checks++;
                if (d !== exp_slice(sel, q[0], k)) begin
                    failures++;
                    $display("FAIL %s data word=%h beat=%0d: got %h want %h", name, q[0], k, d, exp_slice(sel, q[0], k));
                end
                checks++;
                if (l !== (k == ns - 1)) begin
                    failures++;
                    $display("FAIL %s tlast beat=%0d: got %b want %b", name, k, l, k == ns - 1);
                end
            end
            if (pv && !ptr) begin
                checks++;
                if ({v, d, l} !== {1'b1, pd, pl}) begin
                    failures++;
                    $display("FAIL %s stall_hold cyc=%0d: got %b/%h/%b want 1/%h/%b", name, cyc, v, d, l, pd, pl);
                end
            end
            pv = v; ptr = tr; pd = d; pl = l;
            if (v === 1'b1 && tr) begin
                beats++;
                k++;
                if (k == ns) begin
                    k = 0;
                    if (q.size() > 0) void'(q.pop_front());
                end
            end
            if (idx < words.size() && r === 1'b1) begin
                q.push_back(words[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        drive(sel, 1'b0, 32'd0, 1'b0);
        checks++;
        if (beats != words.size() * ns || idx != words.size()) begin
            failures++;
            $display("FAIL %s completion: got beats=%0d accepted=%0d want beats=%0d accepted=%0d",
                     name, beats, idx, words.size() * ns, words.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        align = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            logic v, l, r, b;
            logic [3:0] d;
            observe(s, v, d, l, r, b);
            checks++;
            if ({v, l, r, b, d} !== 8'h00) begin
                failures++;
                $display("FAIL reset inst=%0d: got v=%b l=%b rdy=%b busy=%b d=%h want all 0", s, v, l, r, b, d);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_release: got %b want 1", a_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lanes1();
        words = '{32'hA5A5A5A5};
        run_stream(2, "lanes1_a5", 1'b0, 100);
    endtask

    task automatic test_nibble_order();
        words = '{32'h12345678};
        run_stream(0, "nibble_msb", 1'b0, 50);
        words = '{32'h12345678};
        run_stream(1, "nibble_lsb", 1'b0, 50);
    endtask

    task automatic test_back_to_back();
        words = '{32'hCCCCCCCC, 32'hDDDDDDDD, $urandom()};
        run_stream(0, "back_to_back", 1'b0, 60);
    endtask

    task automatic test_flow_control();
        words = '{$urandom(), $urandom(), $urandom()};
        run_stream(0, "flow_msb4", 1'b1, 400);
        words = '{$urandom(), $urandom(), $urandom()};
        run_stream(1, "flow_lsb4", 1'b1, 400);
        words = '{$urandom(), $urandom()};
        run_stream(2, "flow_lanes1", 1'b1, 800);
    endtask

    task automatic test_align();
        drive(0, 1'b1, 32'hDEADBEEF, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({a_vout, a_dout, a_last} !== {1'b1, exp_slice(0, 32'hDEADBEEF, k), 1'b0}) begin
                failures++;
                $display("FAIL align_pre beat=%0d: got %b/%h/%b want 1/%h/0", k, a_vout, a_dout, a_last, exp_slice(0, 32'hDEADBEEF, k));
            end
            @(posedge clk);
            #1;
        end
        align = 1'b1;
        drive(0, 1'b1, 32'h0F0F0F0F, 1'b0);
        @(negedge clk);
        checks++;
        if (a_rdy !== 1'b0) begin
            failures++;
            $display("FAIL align_ready: got %b want 0", a_rdy);
        end
        @(posedge clk);
        #1;
        align = 1'b0;
        drive(0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({a_vout, a_busy, a_last, a_rdy} !== 4'b0001) begin
            failures++;
            $display("FAIL align_flush: got v=%b busy=%b l=%b rdy=%b want 0 0 0 1", a_vout, a_busy, a_last, a_rdy);
        end
        @(posedge clk);
        #1;
        words = '{32'h0F0F0F0F};
        run_stream(0, "after_align", 1'b0, 50);
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, 32'h11112222, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 32'h33334444, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 32'h55556666, 1'b0);
        @(negedge clk);
        checks++;
        if ({a_vout, a_rdy, a_busy} !== 3'b101) begin
            failures++;
            $display("FAIL reset_mid_full: got v=%b rdy=%b busy=%b want 1 0 1", a_vout, a_rdy, a_busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ready: got %b want 0", a_rdy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({a_vout, a_busy, a_last, a_rdy} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_clear: got v=%b busy=%b l=%b rdy=%b want 0 0 0 1", a_vout, a_busy, a_last, a_rdy);
        end
        @(posedge clk);
        #1;
        words = '{$urandom()};
        run_stream(0, "after_reset", 1'b0, 50);
    endtask

    initial begin
        test_reset();
        test_lanes1();
        test_nibble_order();
        test_back_to_back();
        test_flow_control();
        test_align();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
